// File: rtl/adder_sum_accumulator_pkg.sv
// Shared types and defaults for the adder frame-sum accumulator.
package adder_sum_accumulator_pkg;

    localparam int unsigned SUM_W_DEF = 5;
    localparam int unsigned ACC_W_DEF = 8;
    localparam int unsigned COUNT_DEF = 4;
    localparam int unsigned IDX_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/adder_sum_accumulator_if.sv
// Input sum stream and output frame-result stream of the accumulator.
interface adder_sum_accumulator_if
    import adder_sum_accumulator_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic             out_overflow;
    logic [IDX_W-1:0] frame_idx;

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_total, out_overflow, frame_idx
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_total, out_overflow, frame_idx
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates COUNT adder sums per frame and presents the total with a
// sticky overflow flag on a valid/ready output.
module adder_sum_accumulator
    import adder_sum_accumulator_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned COUNT = COUNT_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    adder_sum_accumulator_if.slave   bus
);

    state_e           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0] total_nxt;
    logic             ovf, ovf_nxt;
    logic             ovfo_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [ACC_W:0]   sum_ext;
    logic             accept;

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.frame_idx = idx;

    // Next-state and datapath update; clear behaves like reset.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        idx_nxt   = idx;
        total_nxt = bus.out_total;
        ovfo_nxt  = bus.out_overflow;
        sum_ext   = (ACC_W+1)'(acc) + (ACC_W+1)'(bus.in_sum);

        if (clear) begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            idx_nxt   = '0;
            total_nxt = '0;
            ovfo_nxt  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc_nxt   = ACC_W'(bus.in_sum);
                        ovf_nxt   = 1'b0;
                        idx_nxt   = IDX_W'(1);
                        state_nxt = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_nxt = sum_ext[ACC_W-1:0];
                        ovf_nxt = ovf | sum_ext[ACC_W];
                        idx_nxt = idx + IDX_W'(1);
                        if (idx_nxt == IDX_W'(COUNT)) begin
                            state_nxt = ST_HOLD;
                            total_nxt = acc_nxt;
                            ovfo_nxt  = ovf_nxt;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_valid && bus.out_ready) begin
                        acc_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        idx_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            acc              <= '0;
            ovf              <= 1'b0;
            idx              <= '0;
            bus.out_total    <= '0;
            bus.out_overflow <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.in_ready     <= 1'b1;
        end else begin
            state            <= state_nxt;
            acc              <= acc_nxt;
            ovf              <= ovf_nxt;
            idx              <= idx_nxt;
            bus.out_total    <= total_nxt;
            bus.out_overflow <= ovfo_nxt;
            bus.out_valid    <= (state_nxt == ST_HOLD);
            bus.in_ready     <= (state_nxt != ST_HOLD);
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: two instances (ACC_W=8 and ACC_W=6) share one stimulus.
module tb_adder_sum_accumulator;

    localparam int unsigned COUNT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [4:0] in_sum;
    logic       out_ready;

    int vectors = 0;
    int errors  = 0;

    adder_sum_accumulator_if #(.SUM_W(5), .ACC_W(8)) bus8 ();
    adder_sum_accumulator_if #(.SUM_W(5), .ACC_W(6)) bus6 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_sum    = in_sum;
    assign bus8.out_ready = out_ready;
    assign bus6.in_valid  = in_valid;
    assign bus6.in_sum    = in_sum;
    assign bus6.out_ready = out_ready;

    adder_sum_accumulator #(.SUM_W(5), .COUNT(COUNT), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus8.slave)
    );
    adder_sum_accumulator #(.SUM_W(5), .COUNT(COUNT), .ACC_W(6)) dut6 (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus6.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: true integer sum of the frame, result held once COUNT sums arrive.
    bit m_hold    = 1'b0;
    bit m_started = 1'b0;
    int m_cnt     = 0;
    int m_sum     = 0;
    int m_last    = 0;

    always @(posedge clk) begin
        if (rst || clear) begin
            m_hold = 1'b0;
            m_cnt  = 0;
            m_sum  = 0;
            m_last = 0;
            if (rst) m_started = 1'b1;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 1'b0;
                m_cnt  = 0;
                m_sum  = 0;
            end
        end else if (in_valid) begin
            m_sum = m_sum + int'(in_sum);
            m_cnt = m_cnt + 1;
            if (m_cnt == COUNT) begin
                m_hold = 1'b1;
                m_last = m_sum;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready",   int'(bus8.in_ready),     int'(!m_hold));
            check("out_valid",  int'(bus8.out_valid),    int'(m_hold));
            check("frame_idx",  int'(bus8.frame_idx),    m_cnt);
            check("total8",     int'(bus8.out_total),    m_last % 256);
            check("ovf8",       int'(bus8.out_overflow), int'(m_last > 255));
            check("out_valid6", int'(bus6.out_valid),    int'(m_hold));
            check("total6",     int'(bus6.out_total),    m_last % 64);
            check("ovf6",       int'(bus6.out_overflow), int'(m_last > 63));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_sum   = 5'(s);
        while (!acc && n < 50) begin
            acc = bus8.in_ready;
            step();
            n++;
        end
        if (!acc) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic expect_frame(input string nm, input int t8, input int o8,
                                input int t6, input int o6);
        int n;
        n = 0;
        while (!bus8.out_valid && n < 50) begin
            step();
            n++;
        end
        check({nm, "_valid"}, int'(bus8.out_valid),    1);
        check({nm, "_t8"},    int'(bus8.out_total),    t8);
        check({nm, "_o8"},    int'(bus8.out_overflow), o8);
        check({nm, "_t6"},    int'(bus6.out_total),    t6);
        check({nm, "_o6"},    int'(bus6.out_overflow), o6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({nm, "_ready_after"}, int'(bus8.in_ready),  1);
        check({nm, "_idx_after"},   int'(bus8.frame_idx), 0);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", int'(bus8.out_valid), 0);
        check("rst_ready", int'(bus8.in_ready),  1);
        check("rst_idx",   int'(bus8.frame_idx), 0);
        check("rst_total", int'(bus8.out_total), 0);

        // Back-to-back frame: result must be visible immediately after the 4th accept.
        push(16); push(18); push(20); push(22);
        check("b2b_latency", int'(bus8.out_valid), 1);
        expect_frame("b2b", 76, 0, 12, 1);

        // Narrow accumulator overflows and wraps.
        push(20); push(20); push(20); push(20);
        expect_frame("ovf", 80, 0, 16, 1);

        // Backpressure: result held, new input refused.
        push(31); push(31); push(31); push(31);
        in_valid = 1'b1;
        in_sum   = 5'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", int'(bus8.in_ready),  0);
            check("bp_total", int'(bus8.out_total), 124);
            check("bp_t6",    int'(bus6.out_total), 60);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_ready", int'(bus8.in_ready),  1);
        check("bp_release_idx",   int'(bus8.frame_idx), 0);
        step();
        in_valid = 1'b0;
        check("bp_next_accept", int'(bus8.frame_idx), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("bp_clear_idx", int'(bus8.frame_idx), 0);

        // Gapped input.
        push(1);
        check("gap_idx1", int'(bus8.frame_idx), 1);
        repeat (3) step();
        push(2);
        check("gap_idx2", int'(bus8.frame_idx), 2);
        step();
        push(3);
        check("gap_idx3", int'(bus8.frame_idx), 3);
        push(4);
        check("gap_idx4", int'(bus8.frame_idx), 4);
        expect_frame("gap", 10, 0, 10, 0);

        // Abort mid-frame; the offered sum is dropped as well.
        push(5); push(6);
        in_valid = 1'b1;
        in_sum   = 5'd7;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("abort_idx",   int'(bus8.frame_idx), 0);
        check("abort_valid", int'(bus8.out_valid), 0);
        push(1); push(1); push(1); push(1);
        expect_frame("abort_next", 4, 0, 4, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            clear     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sum    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst       = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
